// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into SHORT / LONG / REPEAT key events for one
// button at a time (lowest index wins), delivered through a one-entry valid/ready slot.
module button_event_ctrl #(
   parameter int N_BTN      = 4,
   parameter int LONG_CYC   = 1000,
   parameter int REPEAT_CYC = 200,
   parameter int CNT_W      = 16,
   localparam int IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_db,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_idx,
   output logic [1:0]       evt_type,
   output logic             evt_drop,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

   localparam logic [1:0]       T_SHORT   = 2'b00;
   localparam logic [1:0]       T_LONG    = 2'b01;
   localparam logic [1:0]       T_REPEAT  = 2'b10;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
   logic [N_BTN-1:0]   btn_q;
   logic               evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0]   evt_idx_q, evt_idx_d;
   logic [1:0]         evt_type_q, evt_type_d;
   logic               evt_drop_q, evt_drop_d;
   logic               busy_q, busy_d;

   logic [N_BTN-1:0]   rise;
   logic [IDX_W-1:0]   rise_idx;
   logic               lock_lvl;
   logic               emit;
   logic [1:0]         emit_type;
   logic               slot_free;

   assign rise     = btn_db & ~btn_q;
   assign lock_lvl = btn_db[lock_idx_q];

   // Scan downward so the lowest set bit is the one that sticks.
   always_comb begin
      rise_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (rise[i]) rise_idx = IDX_W'(i);
      end
   end

   // State register (btn_q resets high so a button held through reset is not a press).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         lock_idx_q <= '0;
         btn_q      <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_idx_q <= lock_idx_d;
         btn_q      <= btn_db;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         S_IDLE: begin
            if (|rise) begin
               lock_idx_d = rise_idx;
               cnt_d      = '0;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!lock_lvl) begin
               state_d = S_IDLE;
            end else if (cnt_q == LONG_LAST) begin
               cnt_d   = '0;
               state_d = S_REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPEAT: begin
            if (!lock_lvl)               state_d = S_IDLE;
            else if (cnt_q == REP_LAST)  cnt_d   = '0;
            else                         cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Event decode from the current state and held level
   always_comb begin
      emit      = 1'b0;
      emit_type = T_SHORT;
      case (state_q)
         S_HOLD: begin
            if (!lock_lvl) begin
               emit      = 1'b1;
               emit_type = T_SHORT;
            end else if (cnt_q == LONG_LAST) begin
               emit      = 1'b1;
               emit_type = T_LONG;
            end
         end
         S_REPEAT: begin
            if (lock_lvl && cnt_q == REP_LAST) begin
               emit      = 1'b1;
               emit_type = T_REPEAT;
            end
         end
         default: ;
      endcase
   end

   // Output slot: a same-cycle accept frees the slot for a reload.
   assign slot_free = ~evt_valid_q | evt_ready;

   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_idx_d   = evt_idx_q;
      evt_type_d  = evt_type_q;
      evt_drop_d  = 1'b0;
      busy_d      = (state_d != S_IDLE);
      if (emit) begin
         if (slot_free) begin
            evt_valid_d = 1'b1;
            evt_idx_d   = lock_idx_q;
            evt_type_d  = emit_type;
         end else begin
            evt_drop_d  = 1'b1;
         end
      end else if (evt_ready) begin
         evt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid_q <= 1'b0;
         evt_idx_q   <= '0;
         evt_type_q  <= T_SHORT;
         evt_drop_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         evt_valid_q <= evt_valid_d;
         evt_idx_q   <= evt_idx_d;
         evt_type_q  <= evt_type_d;
         evt_drop_q  <= evt_drop_d;
         busy_q      <= busy_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_idx   = evt_idx_q;
   assign evt_type  = evt_type_q;
   assign evt_drop  = evt_drop_q;
   assign busy      = busy_q;

endmodule
